// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage: issues word reads, latches the returned
// instruction, and handles redirects and downstream stalls.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        FLUSH = 2'd3
    } state_e;

    state_e      state_q,      state_d;
    logic [31:0] fetch_pc_q,   fetch_pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;
    logic [31:0] instr_q,      instr_d;
    logic [31:0] pc_q,         pc_d;
    logic        valid_q,      valid_d;
    logic [31:0] target;

    assign target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no path can infer a latch.
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        valid_d      = valid_q;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (redirect) fetch_pc_d = target;
            end
            FETCH: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    if (imem_ready) begin
                        fetch_pc_d = target;
                    end else begin
                        // The request is still in flight: keep its address on the bus.
                        pending_pc_d = target;
                        state_d      = FLUSH;
                    end
                end else if (imem_ready) begin
                    instr_d    = imem_rdata;
                    pc_d       = fetch_pc_q;
                    valid_d    = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (redirect) begin
                    valid_d    = 1'b0;
                    fetch_pc_d = target;
                    state_d    = FETCH;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    pending_pc_d = target;
                end else if (imem_ready) begin
                    fetch_pc_d = pending_pc_q;
                    state_d    = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (rst) begin
            state_q      <= BOOT;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= RESET_PC;
            instr_q      <= 32'h0;
            pc_q         <= RESET_PC;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_req    = (state_q == FETCH) || (state_q == FLUSH);
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[6:0];
    assign pc          = pc_q;

endmodule
